// File: rtl/mircore_pkg.sv
// Shared definitions for the BIOS boot path.
//   - state encoding of the boot sequencer FSM
//   - datapath word width and nominal BIOS ROM depth
//   - instruction-memory write request bundle
package mircore_pkg;

  localparam int WORD_W     = 32;
  localparam int BIOS_DEPTH = 64;

  localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
  localparam logic [1:0] ST_PRIME_ENC  = 2'd1;
  localparam logic [1:0] ST_STREAM_ENC = 2'd2;
  localparam logic [1:0] ST_DONE_ENC   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_PRIME  = ST_PRIME_ENC,
    ST_STREAM = ST_STREAM_ENC,
    ST_DONE   = ST_DONE_ENC
  } boot_state_t;

  typedef struct packed {
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } imem_wr_t;

endpackage

// File: rtl/bios_copy_counter.sv
// Read/write pointer pair for the BIOS copy.
//   clk_auto, reset_n : clock, async active-low reset
//   clr               : zero both pointers (start of a new copy)
//   inc_rd, inc_wr    : advance read / write pointer this edge
//   wr_ptr            : current instruction-memory word offset
//   rd_addr           : ROM word address, clamped to COPY_LEN-1
//   last              : write pointer is on the final word
module bios_copy_counter
  import mircore_pkg::*;
#(
  parameter int BIOS_WORDS = BIOS_DEPTH,
  parameter int COPY_LEN   = 47,
  localparam int PW        = $clog2(BIOS_WORDS) + 1
) (
  input  logic          clk_auto,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          inc_rd,
  input  logic          inc_wr,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_addr,
  output logic          last
);

  localparam logic [PW-1:0] ONE  = PW'(1);
  localparam logic [PW-1:0] LEN  = PW'(COPY_LEN);
  localparam logic [PW-1:0] LAST = PW'(COPY_LEN - 1);

  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk_auto or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (inc_rd) rd_ptr <= rd_ptr + ONE;
      if (inc_wr) wr_ptr <= wr_ptr + ONE;
    end
  end

  // rd_ptr runs one ahead of wr_ptr and reaches COPY_LEN on the final
  // write cycle; the ROM address is held on the last real word instead.
  assign rd_addr = (rd_ptr < LEN) ? rd_ptr : LAST;
  assign last    = (wr_ptr == LAST);

endmodule

// File: rtl/bios_boot_sequencer.sv
// BIOS boot sequencer: after reset (or a start pulse) copies the first
// COPY_LEN BIOS ROM words into instruction memory while holding the CPU,
// then releases the CPU and hands the ROM address port to its fetch path.
//   clk_auto, reset_n : clock, async active-low reset
//   start             : one-cycle (re)load request
//   cpu_fetch_addr    : CPU ROM address, forwarded only once DONE
//   bios_addr/data    : ROM port (data registered, one edge behind addr)
//   imem_we/addr/wdata: instruction-memory write port
//   cpu_hold          : CPU stall
//   busy / done       : copy in progress / copy complete
module bios_boot_sequencer
  import mircore_pkg::*;
#(
  parameter int          BIOS_WORDS = BIOS_DEPTH,
  parameter int          COPY_LEN   = 47,
  parameter int unsigned IMEM_BASE  = 0,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic              clk_auto,
  input  logic              reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] cpu_fetch_addr,
  output logic [WORD_W-1:0] bios_addr,
  input  logic [WORD_W-1:0] bios_data,
  output logic              imem_we,
  output logic [WORD_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done
);

  localparam int PW = $clog2(BIOS_WORDS) + 1;

  if (COPY_LEN < 1 || COPY_LEN > BIOS_WORDS) begin : g_len_chk
    $error("bios_boot_sequencer: COPY_LEN must be in 1..BIOS_WORDS");
  end
  if (64'(IMEM_BASE) + 64'(COPY_LEN) - 64'd1 > 64'hFFFF_FFFF) begin : g_base_chk
    $error("bios_boot_sequencer: IMEM_BASE+COPY_LEN-1 overflows 32 bits");
  end

  boot_state_t   state, state_nxt;
  logic          go_prime;
  logic [PW-1:0] wr_ptr, rd_addr;
  logic          last;
  imem_wr_t      wr;

  bios_copy_counter #(
    .BIOS_WORDS (BIOS_WORDS),
    .COPY_LEN   (COPY_LEN)
  ) u_cnt (
    .clk_auto (clk_auto),
    .reset_n  (reset_n),
    .clr      (go_prime),
    .inc_rd   (busy),
    .inc_wr   (state == ST_STREAM),
    .wr_ptr   (wr_ptr),
    .rd_addr  (rd_addr),
    .last     (last)
  );

  always_ff @(posedge clk_auto or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Outputs are pure decode of state/pointers: the write data is the ROM
  // output straight through, which already lines up with wr_ptr because
  // the ROM lags the read pointer by exactly one edge.
  always_comb begin
    state_nxt = state;
    go_prime  = 1'b0;
    bios_addr = '0;
    cpu_hold  = 1'b1;
    busy      = 1'b0;
    done      = 1'b0;
    wr.we     = 1'b0;
    wr.addr   = WORD_W'(IMEM_BASE) + WORD_W'(wr_ptr);
    wr.data   = bios_data;
    unique case (state)
      ST_IDLE: begin
        if (AUTO_START || start) begin
          state_nxt = ST_PRIME;
          go_prime  = 1'b1;
        end
      end
      ST_PRIME: begin
        busy      = 1'b1;
        bios_addr = WORD_W'(rd_addr);
        state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        busy      = 1'b1;
        wr.we     = 1'b1;
        bios_addr = WORD_W'(rd_addr);
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        cpu_hold  = 1'b0;
        done      = 1'b1;
        bios_addr = cpu_fetch_addr;
        if (start) begin
          state_nxt = ST_PRIME;
          go_prime  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign imem_we    = wr.we;
  assign imem_addr  = wr.addr;
  assign imem_wdata = wr.data;

endmodule

// File: tb/tb_bios_boot_sequencer.sv
// Bench for bios_boot_sequencer. Four instances cover the default 47-word
// auto-start copy, a based 4-word start-driven copy, and the 1- and
// 64-word edge cases. A monitor logs every instruction-memory write; each
// finished copy is compared against what the ROM contents and the
// start-edge timing say it must be.
module tb_bios_boot_sequencer;

  localparam int NI = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0_n, rst1_n;
  logic        st[NI];
  logic [31:0] fa[NI], ba[NI], bd[NI], ia[NI], wd[NI];
  logic        we[NI], hold[NI], busy[NI], done[NI];
  logic [31:0] rom[64];
  int          cyc = 0;

  // registered-read ROM, one per instance
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NI; i++) bd[i] <= rom[ba[i][5:0]];
  end

  bios_boot_sequencer u0 (
    .clk_auto(clk), .reset_n(rst0_n), .start(st[0]), .cpu_fetch_addr(fa[0]),
    .bios_addr(ba[0]), .bios_data(bd[0]), .imem_we(we[0]), .imem_addr(ia[0]),
    .imem_wdata(wd[0]), .cpu_hold(hold[0]), .busy(busy[0]), .done(done[0]));

  bios_boot_sequencer #(.COPY_LEN(4), .IMEM_BASE(16), .AUTO_START(1'b0)) u1 (
    .clk_auto(clk), .reset_n(rst1_n), .start(st[1]), .cpu_fetch_addr(fa[1]),
    .bios_addr(ba[1]), .bios_data(bd[1]), .imem_we(we[1]), .imem_addr(ia[1]),
    .imem_wdata(wd[1]), .cpu_hold(hold[1]), .busy(busy[1]), .done(done[1]));

  bios_boot_sequencer #(.COPY_LEN(1), .AUTO_START(1'b0)) u2 (
    .clk_auto(clk), .reset_n(rst1_n), .start(st[2]), .cpu_fetch_addr(fa[2]),
    .bios_addr(ba[2]), .bios_data(bd[2]), .imem_we(we[2]), .imem_addr(ia[2]),
    .imem_wdata(wd[2]), .cpu_hold(hold[2]), .busy(busy[2]), .done(done[2]));

  bios_boot_sequencer #(.COPY_LEN(64), .AUTO_START(1'b0)) u3 (
    .clk_auto(clk), .reset_n(rst1_n), .start(st[3]), .cpu_fetch_addr(fa[3]),
    .bios_addr(ba[3]), .bios_data(bd[3]), .imem_we(we[3]), .imem_addr(ia[3]),
    .imem_wdata(wd[3]), .cpu_hold(hold[3]), .busy(busy[3]), .done(done[3]));

  // ---- monitor ----
  typedef struct {
    int          inst;
    int          c;
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         wq[$];
  int          done_cyc[NI] = '{default: -1};
  int          hold_cyc[NI] = '{default: -1};
  logic [31:0] max_ba[NI]   = '{default: 0};
  logic        done_q[NI]   = '{default: 1'b0};
  logic        hold_q[NI]   = '{default: 1'b1};

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (we[i] === 1'b1) wq.push_back('{i, cyc, ia[i], wd[i]});
      if (done[i] === 1'b1 && !done_q[i]) done_cyc[i] <= cyc;
      if (hold[i] === 1'b0 && hold_q[i]) hold_cyc[i] <= cyc;
      if (busy[i] === 1'b1 && ba[i] > max_ba[i]) max_ba[i] <= ba[i];
      done_q[i] <= (done[i] === 1'b1);
      hold_q[i] <= (hold[i] !== 1'b0);
    end
  end

  // ---- checking ----
  int n_chk = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic nc();
    @(negedge clk);
    #1;
  endtask

  // start sampled at the next edge, which is E0 of the copy
  task automatic pulse(input int i, output int e0);
    st[i] = 1'b1;
    e0 = cyc + 1;
    nc();
    st[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int lim);
    for (int k = 0; k < lim && done[i] !== 1'b1; k++) nc();
    chk($sformatf("tmo%0d", i), 32'(done[i]), 1);
  endtask

  function automatic int nwr(input int i);
    int n = 0;
    foreach (wq[j]) if (wq[j].inst == i) n++;
    return n;
  endfunction

  task automatic purge(input int i);
    for (int j = wq.size() - 1; j >= 0; j--) if (wq[j].inst == i) wq.delete(j);
  endtask

  // Expected copy: word k goes to base+k carrying rom[k], written in the
  // cycle after edge E(k+1); done and cpu release follow E(len+1).
  task automatic chk_copy(input string tag, input int i, input int base,
                          input int len, input int e0);
    int k = 0;
    foreach (wq[j]) begin
      if (wq[j].inst == i) begin
        if (k < len) begin
          chk($sformatf("%s_a%0d", tag, k), wq[j].a, 32'(base + k));
          chk($sformatf("%s_d%0d", tag, k), wq[j].d, rom[k]);
          chk($sformatf("%s_c%0d", tag, k), 32'(wq[j].c), 32'(e0 + 1 + k));
        end
        k++;
      end
    end
    chk({tag, "_n"}, 32'(k), 32'(len));
    chk({tag, "_done"}, 32'(done_cyc[i]), 32'(e0 + len + 1));
    chk({tag, "_hold"}, 32'(hold_cyc[i]), 32'(e0 + len + 1));
    purge(i);
  endtask

  initial begin
    int e0, k;
    logic [31:0] r;
    for (int j = 0; j < 64; j++) rom[j] = 32'hA000_0000 + 32'(j);
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      st[i] = 1'b0;
      fa[i] = '0;
    end
    repeat (3) nc();
    chk("rst_we", 32'(we[0]), 0);
    chk("rst_hold", 32'(hold[0]), 1);
    chk("rst_busy", 32'(busy[0]), 0);
    chk("rst_done", 32'(done[0]), 0);
    chk("rst_ba", ba[0], 0);

    // auto-start copy with a stray start pulse mid-stream
    rst0_n = 1'b1;
    rst1_n = 1'b1;
    e0 = cyc + 1;
    k = $urandom_range(3, 40);
    repeat (k) nc();
    chk("strm_busy", 32'(busy[0]), 1);
    st[0] = 1'b1;
    nc();
    st[0] = 1'b0;
    chk("idle1_busy", 32'(busy[1]), 0);
    chk("idle1_hold", 32'(hold[1]), 1);
    wait_done(0, 200);
    chk_copy("c0", 0, 0, 47, e0);
    chk("c0_hold0", 32'(hold[0]), 0);

    // fetch pass-through in DONE
    fa[0] = 32'd5;
    #1 chk("fa5", ba[0], 32'd5);
    fa[0] = 32'd46;
    #1 chk("fa46", ba[0], 32'd46);
    r = $urandom;
    fa[0] = r;
    #1 chk("fa_rnd", ba[0], r);

    // reload with fresh random ROM contents
    nc();
    for (int j = 0; j < 64; j++) rom[j] = $urandom;
    pulse(0, e0);
    chk("rl_hold", 32'(hold[0]), 1);
    chk("rl_done", 32'(done[0]), 0);
    wait_done(0, 200);
    chk_copy("c1", 0, 0, 47, e0);

    // reset in the middle of a stream
    pulse(0, e0);
    for (int t = 0; t < 100 && nwr(0) < 10; t++) nc();
    chk("ab_n", 32'(nwr(0)), 10);
    chk("ab_we1", 32'(we[0]), 1);
    #2 rst0_n = 1'b0;
    #1;
    chk("ab_we0", 32'(we[0]), 0);
    chk("ab_hold", 32'(hold[0]), 1);
    chk("ab_done", 32'(done[0]), 0);
    nc();
    nc();
    purge(0);
    rst0_n = 1'b1;
    e0 = cyc + 1;
    wait_done(0, 200);
    chk_copy("c2", 0, 0, 47, e0);

    // based short copy, start-driven
    pulse(1, e0);
    wait_done(1, 50);
    chk_copy("c3", 1, 16, 4, e0);
    chk("c3_hold0", 32'(hold[1]), 0);

    // single-word copy
    pulse(2, e0);
    wait_done(2, 20);
    chk_copy("c4", 2, 0, 1, e0);

    // full-depth copy, ROM address must clamp at 63
    pulse(3, e0);
    wait_done(3, 200);
    chk_copy("c5", 3, 0, 64, e0);
    chk("c5_maxba", max_ba[3], 32'd63);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
